seq_multiplier: RTL

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/mult_pkg.sv | 12 +
 rtl/seq_mult_datapath.sv | 82 ++++++++
 rtl/seq_multiplier.sv | 98 +++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;

    localparam int unsigned MULT_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult_datapath.sv
// Operand shift registers, accumulator and final sign fix-up of the multiplier.
// Signed operation is built only when SEQ_MULT_SIGNED_EN is defined.
module seq_mult_datapath
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 finish,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]    mcand_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    acc_sum;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Sum including the current step, so the last add lands in the result on the final edge.
    assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_q;
    logic neg_d;

    // Negating -2^(WIDTH-1) wraps back to the same bit pattern, which is the correct unsigned magnitude.
    always_comb begin
        a_mag = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        neg_d = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        prod  = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else if (load) begin
            neg_q <= neg_d;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = signed_mode;
    assign a_mag         = a;
    assign b_mag         = b;
    assign prod          = acc_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result   <= '0;
        end else begin
            if (load) begin
                mcand_q  <= PW'(a_mag);
                mplier_q <= b_mag;
                acc_q    <= '0;
            end else if (step) begin
                acc_q    <= acc_sum;
                mplier_q <= mplier_q >> 1;
                mcand_q  <= mcand_q << 1;
            end
            if (finish) begin
                result <= prod;
            end
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential WIDTH-cycle shift-and-add multiplier: control FSM and iteration counter.
// Define SEQ_MULT_SIGNED_EN to honour inp_signed (two's-complement operands).
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH_DEF,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 inp_clk,
    input  logic                 inp_rst_n,
    input  logic                 inp_start,
    input  logic [WIDTH-1:0]     inp_a,
    input  logic [WIDTH-1:0]     inp_b,
    input  logic                 inp_signed,
    output logic [2*WIDTH-1:0]   out_result,
    output logic                 out_busy,
    output logic                 out_done
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             load;
    logic             step;
    logic             finish;
    logic             busy_d;
    logic             done_d;

    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            out_busy <= 1'b0;
            out_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_busy <= busy_d;
            out_done <= done_d;
        end
    end

    // Next state, counter and datapath strobes; DONE may re-accept for back-to-back operation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (inp_start) begin
                    load    = 1'b1;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = CALC;
                end
            end
            CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (inp_start) begin
                    load    = 1'b1;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    seq_mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk         (inp_clk),
        .rst_n       (inp_rst_n),
        .load        (load),
        .step        (step),
        .finish      (finish),
        .signed_mode (inp_signed),
        .a           (inp_a),
        .b           (inp_b),
        .result      (out_result)
    );

endmodule
